// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer sitting in front of register_bank.
// Define LSM_USER_BANK_EN to make the S bit select user r13/r14 for transfers.
module ldm_stm_sequencer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              load,
   input  logic              pre,
   input  logic              up,
   input  logic              writeback,
   input  logic              user_bank,
   input  logic [4:0]        mode,
   input  logic [3:0]        base_sel,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       reg_list,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [4:0]        rf_read_sel,
   input  logic [DATA_W-1:0] rf_read_data,
   output logic              rf_write_enable,
   output logic [4:0]        rf_write_sel,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_XFER,
      S_WB,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic              load_q, load_d;
   logic              pre_q, pre_d;
   logic              up_q, up_d;
   logic              wb_q, wb_d;
   logic [4:0]        mode_q, mode_d;
   logic [3:0]        bsel_q, bsel_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [15:0]       list_q, list_d;
   logic [15:0]       rem_q, rem_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] fin_q, fin_d;
   logic              rwe_q, rwe_d;
   logic [4:0]        rsel_q, rsel_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [4:0]        n_cnt;
   logic [ADDR_W-1:0] span;
   logic [15:0]       cur_oh;
   logic [3:0]        cur_idx;
   logic              last_beat;
   logic              xfer_usr;
   logic [4:0]        xfer_sel;
   logic [4:0]        wb_sel;
   logic              wb_ok;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) begin
         c = c + {4'd0, v[i]};
      end
      return c;
   endfunction

   // r13/r14 are banked per mode; everything else is a straight index
   function automatic logic [4:0] map_reg(
      input logic [3:0] r,
      input logic [4:0] m,
      input logic       usr
   );
      logic [4:0] b;
      b = 5'd13;
      if (!usr) begin
         case (m)
            5'b10011: b = 5'd17;
            5'b10111: b = 5'd20;
            5'b10010: b = 5'd23;
            5'b11011: b = 5'd26;
            default:  b = 5'd13;
         endcase
      end
      if (r == 4'd13) begin
         return b;
      end else if (r == 4'd14) begin
         return b + 5'd1;
      end
      return {1'b0, r};
   endfunction

`ifdef LSM_USER_BANK_EN
   logic ub_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         ub_q <= 1'b0;
      end else if (state_q == S_IDLE && start) begin
         ub_q <= user_bank;
      end
   end
   assign xfer_usr = ub_q;
`else
   logic unused_ub;
   assign unused_ub = user_bank;
   assign xfer_usr  = 1'b0;
`endif

   assign n_cnt     = popcount16(list_q);
   assign span      = ADDR_W'({n_cnt, 2'b00});
   assign cur_oh    = rem_q & (~rem_q + 16'd1);
   assign last_beat = (rem_q & ~cur_oh) == 16'd0;
   assign xfer_sel  = map_reg(cur_idx, mode_q, xfer_usr);
   assign wb_sel    = map_reg(bsel_q, mode_q, 1'b0);
   // a loaded base register takes precedence over write-back
   assign wb_ok     = wb_q && !(load_q && list_q[bsel_q]);

   always_comb begin
      cur_idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (cur_oh[i]) cur_idx = 4'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_SETUP;
         S_SETUP: state_d = (n_cnt == 5'd0) ? S_DONE : S_XFER;
         S_XFER:  if (mem_ready && last_beat) state_d = S_WB;
         S_WB:    state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy            = 1'b0;
      done            = 1'b0;
      mem_req         = 1'b0;
      mem_we          = 1'b0;
      mem_addr        = '0;
      mem_wdata       = '0;
      rf_read_sel     = '0;
      rf_write_enable = rwe_q;
      rf_write_sel    = rsel_q;
      rf_write_data   = rdata_q;
      unique case (state_q)
         S_SETUP: busy = 1'b1;
         S_XFER: begin
            busy     = 1'b1;
            mem_req  = 1'b1;
            mem_we   = !load_q;
            mem_addr = addr_q & ~ADDR_W'(3);
            if (!load_q) begin
               rf_read_sel = xfer_sel;
               mem_wdata   = rf_read_data;
            end
         end
         S_WB:    busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      load_d  = load_q;
      pre_d   = pre_q;
      up_d    = up_q;
      wb_d    = wb_q;
      mode_d  = mode_q;
      bsel_d  = bsel_q;
      base_d  = base_q;
      list_d  = list_q;
      rem_d   = rem_q;
      addr_d  = addr_q;
      fin_d   = fin_q;
      rwe_d   = 1'b0;
      rsel_d  = '0;
      rdata_d = '0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               load_d = load;
               pre_d  = pre;
               up_d   = up;
               wb_d   = writeback;
               mode_d = mode;
               bsel_d = base_sel;
               base_d = base_addr;
               list_d = reg_list;
            end
         end
         S_SETUP: begin
            rem_d = list_q;
            fin_d = up_q ? base_q + span : base_q - span;
            // lowest address of the block; beats always ascend
            unique case ({pre_q, up_q})
               2'b01: addr_d = base_q;
               2'b11: addr_d = base_q + ADDR_W'(4);
               2'b00: addr_d = base_q - span + ADDR_W'(4);
               2'b10: addr_d = base_q - span;
            endcase
         end
         S_XFER: begin
            if (mem_ready) begin
               addr_d = addr_q + ADDR_W'(4);
               rem_d  = rem_q & ~cur_oh;
               if (load_q) begin
                  rwe_d   = 1'b1;
                  rsel_d  = xfer_sel;
                  rdata_d = mem_rdata;
               end
            end
         end
         S_WB: begin
            if (wb_ok) begin
               rwe_d   = 1'b1;
               rsel_d  = wb_sel;
               rdata_d = DATA_W'(fin_q);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         load_q  <= 1'b0;
         pre_q   <= 1'b0;
         up_q    <= 1'b0;
         wb_q    <= 1'b0;
         mode_q  <= '0;
         bsel_q  <= '0;
         base_q  <= '0;
         list_q  <= '0;
         rem_q   <= '0;
         addr_q  <= '0;
         fin_q   <= '0;
         rwe_q   <= 1'b0;
         rsel_q  <= '0;
         rdata_q <= '0;
      end else begin
         load_q  <= load_d;
         pre_q   <= pre_d;
         up_q    <= up_d;
         wb_q    <= wb_d;
         mode_q  <= mode_d;
         bsel_q  <= bsel_d;
         base_q  <= base_d;
         list_q  <= list_d;
         rem_q   <= rem_d;
         addr_q  <= addr_d;
         fin_q   <= fin_d;
         rwe_q   <= rwe_d;
         rsel_q  <= rsel_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer: directed table, corner
// sequences and randomized transfers against a transaction-level model.
module tb_ldm_stm_sequencer;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          load = 1'b0;
   logic          pre = 1'b0;
   logic          up = 1'b0;
   logic          writeback = 1'b0;
   logic          user_bank = 1'b0;
   logic [4:0]    mode = 5'b10000;
   logic [3:0]    base_sel = 4'd0;
   logic [AW-1:0] base_addr = '0;
   logic [15:0]   reg_list = '0;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready = 1'b0;
   logic [4:0]    rf_read_sel;
   logic [DW-1:0] rf_read_data;
   logic          rf_write_enable;
   logic [4:0]    rf_write_sel;
   logic [DW-1:0] rf_write_data;
   logic          busy;
   logic          done;

   logic [31:0] bank [32];
   logic [31:0] salt = 32'h0;

   assign rf_read_data = bank[rf_read_sel];
   assign mem_rdata    = mem_addr ^ salt;

   always #5 clk = ~clk;

   ldm_stm_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .start(start), .load(load), .pre(pre),
      .up(up), .writeback(writeback), .user_bank(user_bank), .mode(mode),
      .base_sel(base_sel), .base_addr(base_addr), .reg_list(reg_list),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .rf_read_sel(rf_read_sel), .rf_read_data(rf_read_data),
      .rf_write_enable(rf_write_enable), .rf_write_sel(rf_write_sel),
      .rf_write_data(rf_write_data), .busy(busy), .done(done)
   );

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void check(input string nm, input logic [31:0] act,
                                 input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, want);
      end
   endfunction

   typedef struct {
      logic ld, p, u, w, ub;
      logic [4:0] md;
      logic [3:0] bs;
      logic [31:0] base;
      logic [15:0] lst;
   } xfer_t;

   typedef struct { logic [31:0] a; logic we; logic [31:0] d; int cyc; } beat_t;
   typedef struct { logic [4:0] sel; logic [31:0] d; int cyc; } wr_t;

   typedef struct {
      logic ld, p, u, w;
      logic [4:0] md;
      logic [3:0] bs;
      logic [31:0] base;
      logic [15:0] lst;
      int sb, sl;
      logic [31:0] e_first;
      int e_n;
      logic e_wb;
      logic [4:0] e_sel;
      logic [31:0] e_data;
      int e_done;
   } vec_t;

   int stall_q[$];
   int o_nb, o_done;
   logic [31:0] o_first, o_data;
   logic o_wb;
   logic [4:0] o_sel;

   function automatic logic [4:0] mmap(input logic [3:0] r, input logic [4:0] md,
                                       input logic ub);
      int b13;
      if (r != 4'd13 && r != 4'd14) return {1'b0, r};
      b13 = 13;
      if (!ub) begin
         case (md)
            5'b10011: b13 = 17;
            5'b10111: b13 = 20;
            5'b10010: b13 = 23;
            5'b11011: b13 = 26;
            default:  b13 = 13;
         endcase
      end
      return 5'(b13 + int'(r) - 13);
   endfunction

   task automatic new_bank();
      for (int i = 0; i < 32; i++) bank[i] = $urandom;
      salt = $urandom;
   endtask

   task automatic chk_reset_outs(input string t);
      check({t, "_busy"}, 32'(busy), 32'd0);
      check({t, "_done"}, 32'(done), 32'd0);
      check({t, "_mem_req"}, 32'(mem_req), 32'd0);
      check({t, "_mem_we"}, 32'(mem_we), 32'd0);
      check({t, "_mem_addr"}, mem_addr, 32'd0);
      check({t, "_mem_wdata"}, mem_wdata, 32'd0);
      check({t, "_rf_we"}, 32'(rf_write_enable), 32'd0);
      check({t, "_rf_wsel"}, 32'(rf_write_sel), 32'd0);
      check({t, "_rf_wdata"}, rf_write_data, 32'd0);
      check({t, "_rf_rsel"}, 32'(rf_read_sel), 32'd0);
   endtask

   task automatic run(input xfer_t x);
      int n, T, edone, acc, bi, wc, got_done, bad_busy, bad_stab, reqc, st;
      logic ubx, held;
      logic [31:0] lo, fin;
      int regs[$];
      beat_t eb[$], ob[$];
      beat_t b, hold;
      wr_t ew[$], ow[$];
      wr_t w;
      ubx = 1'b0;
`ifdef LSM_USER_BANK_EN
      ubx = x.ub;
`endif
      n = $countones(x.lst);
      for (int r = 0; r < 16; r++) if (x.lst[r]) regs.push_back(r);
      fin = x.u ? x.base + 32'(4 * n) : x.base - 32'(4 * n);
      if (x.u) lo = x.base + (x.p ? 32'd4 : 32'd0);
      else     lo = x.base - 32'(4 * n) + (x.p ? 32'd0 : 32'd4);
      acc = 1;
      T = 0;
      for (int i = 0; i < n; i++) begin
         st = (i < stall_q.size()) ? stall_q[i] : 0;
         acc = acc + 1 + st;
         T = T + 1 + st;
         b.a = (lo + 32'(4 * i)) & ~32'd3;
         b.we = !x.ld;
         b.d = x.ld ? 32'd0 : bank[mmap(4'(regs[i]), x.md, ubx)];
         b.cyc = acc;
         eb.push_back(b);
         if (x.ld) begin
            w.sel = mmap(4'(regs[i]), x.md, ubx);
            w.d = b.a ^ salt;
            w.cyc = acc + 1;
            ew.push_back(w);
         end
      end
      edone = (n == 0) ? 2 : T + 3;
      if (n > 0 && x.w && !(x.ld && x.lst[x.bs])) begin
         w.sel = mmap(x.bs, x.md, 1'b0);
         w.d = fin;
         w.cyc = edone;
         ew.push_back(w);
      end

      @(negedge clk);
      start = 1'b1; load = x.ld; pre = x.p; up = x.u; writeback = x.w;
      user_bank = x.ub; mode = x.md; base_sel = x.bs;
      base_addr = x.base; reg_list = x.lst; mem_ready = 1'b0;
      bi = 0; wc = 0; held = 1'b0; got_done = -1;
      bad_busy = 0; bad_stab = 0; reqc = 0;
      for (int c = 1; c <= edone + 30; c++) begin
         @(negedge clk);
         if (done && got_done < 0) got_done = c;
         if (busy !== (c < edone)) bad_busy++;
         if (rf_write_enable) begin
            w.sel = rf_write_sel; w.d = rf_write_data; w.cyc = c;
            ow.push_back(w);
         end
         mem_ready = 1'b0;
         if (mem_req) begin
            reqc++;
            if (held && (mem_addr !== hold.a || mem_we !== hold.we ||
                         mem_wdata !== hold.d)) bad_stab++;
            b.a = mem_addr; b.we = mem_we; b.d = mem_wdata; b.cyc = c;
            st = (bi < stall_q.size()) ? stall_q[bi] : 0;
            if (wc < st) begin
               wc++; held = 1'b1; hold = b;
            end else begin
               mem_ready = 1'b1; ob.push_back(b);
               bi++; wc = 0; held = 1'b0;
            end
         end else begin
            held = 1'b0;
         end
         // captured fields must not follow the live inputs; extra starts ignored
         start = 1'($urandom); load = 1'($urandom); pre = 1'($urandom);
         up = 1'($urandom); writeback = 1'($urandom); mode = 5'($urandom);
         base_sel = 4'($urandom); base_addr = $urandom; reg_list = 16'($urandom);
         if (got_done >= 0) break;
      end
      mem_ready = 1'b0;
      start = 1'b0;
      check("done_cycle", 32'(got_done), 32'(edone));
      if (got_done < 0) begin
         reset = 1'b1;
         @(negedge clk);
         @(negedge clk);
         reset = 1'b0;
      end
      @(negedge clk);
      check("idle_after_done", 32'({busy, done, rf_write_enable}), 32'd0);
      check("n_beats", 32'(ob.size()), 32'(eb.size()));
      for (int i = 0; i < ob.size() && i < eb.size(); i++) begin
         check($sformatf("beat%0d_addr", i), ob[i].a, eb[i].a);
         check($sformatf("beat%0d_we", i), 32'(ob[i].we), 32'(eb[i].we));
         check($sformatf("beat%0d_cyc", i), 32'(ob[i].cyc), 32'(eb[i].cyc));
         if (!x.ld) check($sformatf("beat%0d_wdata", i), ob[i].d, eb[i].d);
      end
      check("n_rf_writes", 32'(ow.size()), 32'(ew.size()));
      for (int i = 0; i < ow.size() && i < ew.size(); i++) begin
         check($sformatf("wr%0d_sel", i), 32'(ow[i].sel), 32'(ew[i].sel));
         check($sformatf("wr%0d_data", i), ow[i].d, ew[i].d);
         check($sformatf("wr%0d_cyc", i), 32'(ow[i].cyc), 32'(ew[i].cyc));
      end
      check("busy_bad_cycles", 32'(bad_busy), 32'd0);
      check("stall_unstable", 32'(bad_stab), 32'd0);
      check("req_cycles", 32'(reqc), 32'(T));
      o_nb = ob.size();
      o_first = (ob.size() > 0) ? ob[0].a : 32'd0;
      o_done = got_done;
      o_wb = 1'b0; o_sel = '0; o_data = '0;
      foreach (ow[i]) begin
         if (ow[i].cyc == got_done) begin
            o_wb = 1'b1; o_sel = ow[i].sel; o_data = ow[i].d;
         end
      end
   endtask

   initial begin
      vec_t tbl[10];
      xfer_t x;
      logic [4:0] modes[7];
      int sel;

      tbl[0] = '{0,0,1,1,5'b10000,4'd4,32'h100,16'h0007,-1,0,
                 32'h100,3,1,5'd4,32'h10C,6};
      tbl[1] = '{1,1,0,1,5'b10011,4'd13,32'h200,16'h6001,-1,0,
                 32'h1F4,3,0,5'd0,32'h0,6};
      tbl[2] = '{1,0,1,1,5'b10000,4'd3,32'h40,16'h0008,-1,0,
                 32'h40,1,0,5'd0,32'h0,4};
      tbl[3] = '{0,1,1,1,5'b10010,4'd14,32'h1000,16'h4003,1,3,
                 32'h1004,3,1,5'd24,32'h100C,9};
      tbl[4] = '{0,0,1,1,5'b10000,4'd2,32'h80,16'h0000,-1,0,
                 32'h0,0,0,5'd0,32'h0,2};
      tbl[5] = '{1,0,0,1,5'b10111,4'd0,32'h300,16'h8010,-1,0,
                 32'h2FC,2,1,5'd0,32'h2F8,5};
      tbl[6] = '{0,1,0,1,5'b11011,4'd13,32'h4,16'h0003,-1,0,
                 32'hFFFF_FFFC,2,1,5'd26,32'hFFFF_FFFC,5};
      tbl[7] = '{1,0,1,0,5'b11111,4'd5,32'h0,16'hFFFF,-1,0,
                 32'h0,16,0,5'd0,32'h0,19};
      tbl[8] = '{0,0,1,1,5'b10001,4'd14,32'h500,16'h6000,-1,0,
                 32'h500,2,1,5'd14,32'h508,5};
      tbl[9] = '{0,0,1,1,5'b10000,4'd1,32'h103,16'h0001,0,2,
                 32'h100,1,1,5'd1,32'h107,6};
      modes = '{5'b10000, 5'b11111, 5'b10010, 5'b10011,
                5'b10111, 5'b11011, 5'b10001};

      new_bank();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outs("por");
      reset = 1'b0;

      foreach (tbl[k]) begin
         x = '{tbl[k].ld, tbl[k].p, tbl[k].u, tbl[k].w, 1'b0,
               tbl[k].md, tbl[k].bs, tbl[k].base, tbl[k].lst};
         stall_q.delete();
         if (tbl[k].sb >= 0) begin
            for (int i = 0; i < tbl[k].sb; i++) stall_q.push_back(0);
            stall_q.push_back(tbl[k].sl);
         end
         new_bank();
         run(x);
         check($sformatf("v%0d_first_addr", k), o_first, tbl[k].e_first);
         check($sformatf("v%0d_nbeats", k), 32'(o_nb), 32'(tbl[k].e_n));
         check($sformatf("v%0d_done", k), 32'(o_done), 32'(tbl[k].e_done));
         check($sformatf("v%0d_wb", k), 32'(o_wb), 32'(tbl[k].e_wb));
         if (tbl[k].e_wb) begin
            check($sformatf("v%0d_wb_sel", k), 32'(o_sel), 32'(tbl[k].e_sel));
            check($sformatf("v%0d_wb_data", k), o_data, tbl[k].e_data);
         end
      end

      // abort a load mid-block, then confirm a clean restart
      new_bank();
      @(negedge clk);
      start = 1'b1; load = 1'b1; pre = 1'b0; up = 1'b1; writeback = 1'b1;
      user_bank = 1'b0; mode = 5'b10011; base_sel = 4'd0;
      base_addr = 32'h2000; reg_list = 16'hFFFF; mem_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("midx_req", 32'(mem_req), 32'd1);
      mem_ready = 1'b1;
      @(negedge clk);
      check("midx_wen", 32'(rf_write_enable), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_outs("midx");
      reset = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      check("midx_idle", 32'({busy, mem_req, rf_write_enable}), 32'd0);
      stall_q.delete();
      x = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b10111, 4'd14, 32'h3000, 16'h4101};
      run(x);

      for (int k = 0; k < 120; k++) begin
         x.ld = 1'($urandom); x.p = 1'($urandom); x.u = 1'($urandom);
         x.w = 1'($urandom); x.ub = 1'($urandom);
         x.md = modes[$urandom_range(0, 6)];
         x.bs = 4'($urandom);
         x.base = $urandom;
         sel = int'($urandom_range(0, 7));
         if (sel == 0) x.lst = 16'h0;
         else if (sel == 1) x.lst = 16'(1 << $urandom_range(0, 15));
         else if (sel == 2) x.lst = 16'hFFFF;
         else x.lst = 16'($urandom);
         stall_q.delete();
         for (int i = 0; i < 16; i++)
            stall_q.push_back(($urandom_range(0, 3) == 0) ?
                              int'($urandom_range(1, 3)) : 0);
         new_bank();
         run(x);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
